// File: rtl/dump_framer.sv
// dump_framer: SDRAM readback stage feeding the UART byte interface.
// After start it reads word addresses 0..LAST_ADDR one at a time. Every word
// whose marker bit is set goes out as a fixed-length byte frame. The dump ends
// at the first unmarked word or after LAST_ADDR has been framed.
// Build option: define DUMP_FRAME_SUM_EN to append a 7th byte per frame
// holding the modulo-256 sum of frame bytes 1..5.
module dump_framer #(
    parameter int unsigned       ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFFF,
    parameter int unsigned       GUARD     = 2
) (
    input  logic              clk100,
    input  logic              rst_p,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              end_reason,
    output logic [ADDR_W-1:0] words_sent,
    input  logic              cmd_ready,
    output logic              cmd_enable,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       data_out,
    input  logic              data_out_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_dv,
    input  logic              tx_active
);

    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);
`ifdef DUMP_FRAME_SUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Payload bytes 0..5 of a frame; bit 0 of the word (marker) is not needed.
    function automatic logic [7:0] body_byte(input logic [31:1] w, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (w[1] == 1'b0) begin
            case (idx)
                3'd0:    b = 8'h0A;
                3'd1:    b = {4'h0, w[31:28]};
                3'd2:    b = w[27:20];
                3'd3:    b = {4'h0, w[19:16]};
                3'd4:    b = w[15:8];
                3'd5:    b = {2'b00, w[7:2]};
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h0C;
                3'd1:    b = w[31:24];
                3'd2:    b = w[23:16];
                3'd3:    b = w[15:8];
                3'd4:    b = 8'h00;
                3'd5:    b = {2'b00, w[7:2]};
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

`ifdef DUMP_FRAME_SUM_EN
    // Modulo-256 sum over bytes 1..5; the header byte is deliberately left out.
    function automatic logic [7:0] frame_sum(input logic [31:1] w);
        return body_byte(w, 3'd1) + body_byte(w, 3'd2) + body_byte(w, 3'd3) +
               body_byte(w, 3'd4) + body_byte(w, 3'd5);
    endfunction
`endif

    function automatic logic [7:0] frame_byte(input logic [31:1] w, input logic [2:0] idx);
        logic [7:0] b;
`ifdef DUMP_FRAME_SUM_EN
        if (idx == 3'd6) begin
            b = frame_sum(w);
        end else begin
            b = body_byte(w, idx);
        end
`else
        b = body_byte(w, idx);
`endif
        return b;
    endfunction

    state_t            state_q, state_d;
    logic              cmd_enable_q, cmd_enable_d;
    logic [ADDR_W-1:0] cmd_address_q, cmd_address_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              end_reason_q, end_reason_d;
    logic [ADDR_W-1:0] words_sent_q, words_sent_d;
    logic [31:1]       word_q, word_d;
    logic [2:0]        idx_q, idx_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic              can_send_s;

    // A byte may only leave when the UART is idle and the post-strobe guard expired.
    assign can_send_s = (tx_active == 1'b0) && (guard_q == GW'(0)) && (tx_dv_q == 1'b0);

    // Next-state and registered-output computation for the dump sequencer.
    always_comb begin
        state_d       = state_q;
        cmd_enable_d  = cmd_enable_q;
        cmd_address_d = cmd_address_q;
        tx_byte_d     = tx_byte_q;
        tx_dv_d       = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        end_reason_d  = end_reason_q;
        words_sent_d  = words_sent_q;
        word_d        = word_q;
        idx_d         = idx_q;
        if (guard_q != GW'(0)) begin
            guard_d = guard_q - GW'(1);
        end else begin
            guard_d = guard_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_REQ;
                    cmd_enable_d  = 1'b1;
                    cmd_address_d = {ADDR_W{1'b0}};
                    words_sent_d  = {ADDR_W{1'b0}};
                    busy_d        = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (cmd_enable_q && cmd_ready) begin
                    cmd_enable_d = 1'b0;
                    state_d      = S_WAIT;
                end else begin
                    cmd_enable_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_out_ready) begin
                    word_d = data_out[31:1];
                    if (data_out[0] == 1'b0) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        end_reason_d = 1'b0;
                    end else if (can_send_s) begin
                        // Header goes out straight away to save a cycle of latency.
                        tx_byte_d = frame_byte(data_out[31:1], 3'd0);
                        tx_dv_d   = 1'b1;
                        guard_d   = GUARD_LD;
                        idx_d     = 3'd1;
                        state_d   = S_SEND;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SEND: begin
                if (can_send_s) begin
                    tx_byte_d = frame_byte(word_q, idx_q);
                    tx_dv_d   = 1'b1;
                    guard_d   = GUARD_LD;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_NEXT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_NEXT: begin
                words_sent_d = words_sent_q + ADDR_W'(1);
                // Terminate before incrementing so the address never wraps.
                if (cmd_address_q == LAST_ADDR) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    end_reason_d = 1'b1;
                end else begin
                    cmd_address_d = cmd_address_q + ADDR_W'(1);
                    cmd_enable_d  = 1'b1;
                    state_d       = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                cmd_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any dump in progress at once.
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            state_q       <= S_IDLE;
            cmd_enable_q  <= 1'b0;
            cmd_address_q <= {ADDR_W{1'b0}};
            tx_byte_q     <= 8'h00;
            tx_dv_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            end_reason_q  <= 1'b0;
            words_sent_q  <= {ADDR_W{1'b0}};
            word_q        <= 31'd0;
            idx_q         <= 3'd0;
            guard_q       <= GW'(0);
        end else begin
            state_q       <= state_d;
            cmd_enable_q  <= cmd_enable_d;
            cmd_address_q <= cmd_address_d;
            tx_byte_q     <= tx_byte_d;
            tx_dv_q       <= tx_dv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            end_reason_q  <= end_reason_d;
            words_sent_q  <= words_sent_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            guard_q       <= guard_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign end_reason  = end_reason_q;
    assign words_sent  = words_sent_q;
    assign cmd_enable  = cmd_enable_q;
    assign cmd_wr      = 1'b0;
    assign cmd_address = cmd_address_q;
    assign tx_byte     = tx_byte_q;
    assign tx_dv       = tx_dv_q;

endmodule

// File: tb/tb_dump_framer.sv
// tb_dump_framer: directed and randomised dumps of a 4-word SDRAM image
// (LAST_ADDR = 3) checked against a frame-level reference model.
// Honours DUMP_FRAME_SUM_EN the same way as the design.
module tb_dump_framer;

    localparam int ADDR_W = 23;
    localparam int GUARD  = 2;
    localparam int NWORDS = 4;
`ifdef DUMP_FRAME_SUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    logic              clk100;
    logic              rst_p;
    logic              start;
    logic              busy, done, end_reason;
    logic [ADDR_W-1:0] words_sent;
    logic              cmd_ready, cmd_enable, cmd_wr;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       data_out;
    logic              data_out_ready;
    logic [7:0]        tx_byte;
    logic              tx_dv, tx_active;

    dump_framer #(.ADDR_W(ADDR_W), .LAST_ADDR(23'd3), .GUARD(GUARD)) dut (
        .clk100(clk100), .rst_p(rst_p), .start(start), .busy(busy), .done(done),
        .end_reason(end_reason), .words_sent(words_sent), .cmd_ready(cmd_ready),
        .cmd_enable(cmd_enable), .cmd_wr(cmd_wr), .cmd_address(cmd_address),
        .data_out(data_out), .data_out_ready(data_out_ready), .tx_byte(tx_byte),
        .tx_dv(tx_dv), .tx_active(tx_active)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [31:0] mem [0:NWORDS-1];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         rdy_q[$];
    int         n_reads = 0;
    int         n_strobes = 0;
    int         done_cnt = 0;
    int         first_strobe_cyc = 0;
    int         last_strobe_cyc = -100;
    int         uart_max = 0;
    int         busy_cnt = 0;
    bit         uart_hold = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         rdy_force = 1'b1;
    bit         spur_req = 1'b0;
    bit         prev_active = 1'b0;
    bit         prev_acc = 1'b0;
    int         exp_ws, exp_reads;
    logic       exp_reason;
    int         s0, d0;

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: expected byte stream of one frame, straight from the frame tables.
    function automatic void push_frame(input logic [31:0] w);
        logic [7:0] f [6];
        if (w[1]) f = '{8'h0C, w[31:24], w[23:16], w[15:8], 8'h00, {2'b00, w[7:2]}};
        else      f = '{8'h0A, {4'h0, w[31:28]}, w[27:20], {4'h0, w[19:16]}, w[15:8], {2'b00, w[7:2]}};
        foreach (f[i]) exp_q.push_back(f[i]);
`ifdef DUMP_FRAME_SUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 1; i < 6; i++) s = s + f[i];
            exp_q.push_back(s);
        end
`endif
    endfunction

    // Reference: whole dump outcome for the current memory image.
    function automatic void model();
        exp_q.delete();
        exp_ws = 0; exp_reads = 0; exp_reason = 1'b0;
        for (int a = 0; a < NWORDS; a++) begin
            exp_reads++;
            if (mem[a][0] == 1'b0) begin
                exp_reason = 1'b0;
                break;
            end
            push_frame(mem[a]);
            exp_ws++;
            if (a == NWORDS - 1) exp_reason = 1'b1;
        end
    endfunction

    // UART busy model and SDRAM command-ready driver, updated just after each edge.
    initial begin
        tx_active = 1'b0;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk100); #1;
            if (tx_dv === 1'b1 && uart_max > 0) busy_cnt = int'($urandom_range(0, uart_max));
            else if (busy_cnt > 0) busy_cnt--;
            tx_active = uart_hold || (busy_cnt != 0);
            cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // SDRAM read responder with random latency; data_out is noise when idle.
    initial begin
        logic [1:0] a;
        int unsigned lat;
        data_out = 32'd0;
        data_out_ready = 1'b0;
        forever begin
            @(negedge clk100);
            data_out_ready = 1'b0;
            if (cmd_enable && cmd_ready && !rst_p) begin
                a = cmd_address[1:0];
                @(posedge clk100); #1;
                lat = $urandom_range(0, 3);
                repeat (lat) begin
                    data_out = $urandom;
                    @(posedge clk100); #1;
                end
                data_out = mem[a];
                data_out_ready = 1'b1;
                rdy_q.push_back(cyc);
                @(posedge clk100); #1;
                data_out_ready = 1'b0;
                data_out = $urandom;
            end else begin
                data_out = $urandom;
                if (spur_req) begin
                    data_out_ready = 1'b1;
                    spur_req = 1'b0;
                end
            end
        end
    end

    // Output monitor: collects bytes and checks strobe/command protocol rules.
    initial begin
        forever begin
            @(negedge clk100);
            if (rst_p) begin
                last_strobe_cyc = -100;
                prev_acc = 1'b0;
            end else begin
                if (tx_dv) begin
                    chk("tx_dv_while_active", 32'(prev_active), 32'd0);
                    chk("tx_dv_spacing", 32'((cyc - last_strobe_cyc) >= GUARD + 1), 32'd1);
                    if (rx_q.size() == 0) first_strobe_cyc = cyc;
                    rx_q.push_back(tx_byte);
                    n_strobes++;
                    last_strobe_cyc = cyc;
                end
                if (prev_acc) chk("cmd_enable_drop", 32'(cmd_enable), 32'd0);
                prev_acc = cmd_enable && cmd_ready;
                if (prev_acc) n_reads++;
                if (done) done_cnt++;
            end
            prev_active = tx_active;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_enable"}, 32'(cmd_enable), 32'd0);
        chk({tag, "_cmd_wr"}, 32'(cmd_wr), 32'd0);
        chk({tag, "_cmd_address"}, 32'(cmd_address), 32'd0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_tx_dv"}, 32'(tx_dv), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_end_reason"}, 32'(end_reason), 32'd0);
        chk({tag, "_words_sent"}, 32'(words_sent), 32'd0);
    endtask

    // One complete dump of the current memory image, checked against the model.
    task automatic run_dump(input string tag);
        int got;
        int reads0;
        model();
        rx_q.delete();
        rdy_q.delete();
        reads0 = n_reads;
        @(posedge clk100); #1;
        start = 1'b1;
        @(posedge clk100); #1;
        start = 1'b0;
        @(negedge clk100);
        chk({tag, "_start_cmd_enable"}, 32'(cmd_enable), 32'd1);
        chk({tag, "_start_busy"}, 32'(busy), 32'd1);
        got = 0;
        for (int i = 0; i < 5000 && got == 0; i++) begin
            @(negedge clk100);
            if (done === 1'b1) got = 1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_end_reason"}, 32'(end_reason), 32'(exp_reason));
        chk({tag, "_words_sent"}, 32'(words_sent), 32'(exp_ws));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_cmd_address"}, 32'(cmd_address), 32'(exp_reads - 1));
        chk({tag, "_reads"}, 32'(n_reads - reads0), 32'(exp_reads));
        // A start coinciding with done must be ignored.
        if (got == 1) start = 1'b1;
        @(posedge clk100); #1;
        start = 1'b0;
        repeat (3) @(negedge clk100);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_cmd_enable"}, 32'(cmd_enable), 32'd0);
        chk({tag, "_ws_hold"}, 32'(words_sent), 32'(exp_ws));
        chk({tag, "_cmd_wr"}, 32'(cmd_wr), 32'd0);
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_p = 1'b1;
        start = 1'b0;
        foreach (mem[i]) mem[i] = 32'd0;
        repeat (3) @(negedge clk100);
        check_reset_vals("rst");
        @(posedge clk100); #1;
        rst_p = 1'b0;
        repeat (2) @(negedge clk100);
        check_reset_vals("post_rst");

        // Meter word then unmarked word; UART always idle.
        mem[0] = 32'h12345679; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h0;
        run_dump("meter");
        chk("meter_latency", 32'((rdy_q.size() > 0) ? (first_strobe_cyc - rdy_q[0]) : -1), 32'd1);

        // Logic event word then unmarked word.
        mem[0] = 32'hABCD0003; mem[1] = 32'h0;
        run_dump("logic");

        // Long UART stall mid-frame with data_out churning and a stray ready pulse.
        mem[0] = 32'h12345679; mem[1] = 32'hABCD0003; mem[2] = 32'h0;
        fork
            run_dump("stall");
            begin : stall_ctl
                int c;
                c = 0;
                for (int i = 0; i < 4000 && c < 2; i++) begin
                    @(negedge clk100);
                    if (tx_dv) c++;
                end
                uart_hold = 1'b1;
                repeat (3) @(negedge clk100);
                s0 = n_strobes;
                spur_req = 1'b1;
                repeat (500) @(negedge clk100);
                chk("stall_no_tx_dv", 32'(n_strobes - s0), 32'd0);
                uart_hold = 1'b0;
            end
        join

        // cmd_ready held low for 20 cycles of REQ.
        mem[0] = $urandom | 32'd1; mem[1] = 32'h0;
        rdy_force = 1'b0;
        @(posedge clk100);
        fork
            run_dump("rdy");
            begin : rdy_ctl
                int hi;
                int r0;
                r0 = n_reads;
                hi = 0;
                for (int i = 0; i < 100 && cmd_enable !== 1'b1; i++) @(negedge clk100);
                for (int i = 0; i < 20; i++) begin
                    if (cmd_enable === 1'b1) hi++;
                    @(negedge clk100);
                end
                chk("rdy_enable_held", 32'(hi), 32'd20);
                chk("rdy_no_accept", 32'(n_reads - r0), 32'd0);
                rdy_force = 1'b1;
            end
        join

        // All words marked: runs to LAST_ADDR; a start while busy is ignored.
        foreach (mem[i]) mem[i] = $urandom | 32'd1;
        uart_max = 4;
        rdy_rand = 1'b1;
        fork
            run_dump("full");
            begin
                repeat (30) @(posedge clk100);
                #1 start = 1'b1;
                @(posedge clk100);
                #1 start = 1'b0;
            end
        join

        // Reset during the 3rd byte of the second frame.
        mem[0] = 32'h12345679; mem[1] = 32'hABCD0003; mem[2] = 32'h0; mem[3] = 32'h0;
        uart_max = 0;
        rdy_rand = 1'b0;
        rx_q.delete();
        d0 = done_cnt;
        @(posedge clk100); #1;
        start = 1'b1;
        @(posedge clk100); #1;
        start = 1'b0;
        begin : rst_mid
            int c;
            c = 0;
            for (int i = 0; i < 4000 && c < FRAME_LEN + 3; i++) begin
                @(negedge clk100);
                if (tx_dv) c++;
            end
            chk("rstmid_reached", 32'(c), 32'(FRAME_LEN + 3));
        end
        rst_p = 1'b1;
        #1;
        check_reset_vals("rstmid");
        repeat (2) @(negedge clk100);
        @(posedge clk100); #1;
        rst_p = 1'b0;
        s0 = n_strobes;
        repeat (50) @(negedge clk100);
        chk("rstmid_no_tx", 32'(n_strobes - s0), 32'd0);
        chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstmid_idle", 32'(busy), 32'd0);

        // Randomised images, UART back-pressure and command-ready jitter.
        for (int k = 0; k < 6; k++) begin
            foreach (mem[i]) mem[i] = {$urandom_range(0, 32'hFFFF_FFFF)} & 32'hFFFF_FFFE |
                                     32'($urandom_range(0, 3) != 0);
            uart_max = int'($urandom_range(0, 5));
            rdy_rand = 1'b1;
            run_dump($sformatf("rnd%0d", k));
        end

        // Recovery after everything: repeat the first directed dump.
        uart_max = 0;
        rdy_rand = 1'b0;
        mem[0] = 32'h12345679; mem[1] = 32'h0;
        run_dump("meter_again");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
